display_bin_writer: RTL and testbench
=====================================

// Module: display_bin_writer
// PURPOSE
//  Write-side initiator for the 8-digit display controller's (pos, data_in) write port.
//  Takes a binary value on a start strobe and converts it to BCD by iterative
//  double-dabble, one shift per cycle.
//  Then streams the digits as one write per cycle: pos 0 = least significant digit.
//  When not writing, drives an invalid code so the controller holds its digits.
// PARAMETERS
//  DIGITS  8   number of BCD digits produced/written (1..8)
//  BIN_W   27  width of binary input (27 bits covers 99_999_999)
// PORTS
//  clock     in   1        system clock, all state on rising edge
//  reset     in   1        asynchronous, active-high; forces idle state
//  start     in   1        request conversion+write; sampled only in IDLE
//  value     in   BIN_W    binary number, latched on accepted start
//  pos       out  4        digit position to controller; 4'hF when not writing
//  data_out  out  4        BCD digit to controller; 4'hF when not writing
//  busy      out  1        high in CONV and WRITE states
//  done      out  1        one-cycle pulse after last digit written
//  overflow  out  1        latched on accept: value > 10**DIGITS-1; held until next accept
// BEHAVIOUR
//  Reset values (async, immediate):
//   - pos=4'hF, data_out=4'hF, busy=0, done=0, overflow=0, state=IDLE
//   - BCD shift register and counters are cleared.
//  States: IDLE -> CONV -> WRITE -> DONE -> IDLE.
//  IDLE:
//   - On start=1 at edge k: latch value, compute overflow, clear BCD register, enter CONV.
//   - If overflow, the latched operand is replaced by 10**DIGITS-1 (saturate to all 9s).
//  CONV (cycles k+1..k+BIN_W):
//   - Per cycle, every BCD nibble >=5 gets +3, then {bcd,bin} shifts left by 1.
//   - The add-3 and shift happen in the same cycle, combinationally before the register.
//   - Iteration counter runs 0..BIN_W-1; on the last iteration, go to WRITE.
//  WRITE (cycles k+BIN_W+1 .. k+BIN_W+DIGITS):
//   - In cycle k+BIN_W+1+i, outputs are pos=i, data_out=BCD nibble i.
//   - pos/data_out are registered, glitch-free, and valid for the whole cycle.
//   - Every digit is in 0..9 by construction. Leading zeros are written as 0 (no blanking).
//  DONE (cycle k+BIN_W+DIGITS+1):
//   - done=1, busy=0, pos/data_out=4'hF. Next cycle is IDLE.
//  Default latency (BIN_W=27, DIGITS=8): first write at k+28, done at k+36.
//  start outside IDLE (including DONE) is ignored. value changes after accept are ignored.
//  Reset mid-operation aborts the sequence with no further writes.
//   - Digits already written stay in the controller unless it is also reset (shared reset: all zero).
//  done and busy are never high together. pos is never in 8..14.
// STRUCTURE
//  Package display_pkg:
//   - state enum typedef (IDLE, CONV, WRITE, DONE)
//   - localparam POS_IDLE=4'hF, DATA_IDLE=4'hF
//   - function max_value(DIGITS) = 10**DIGITS-1
//  Sub-module bcd_add3_step (combinational):
//   - DIGITS nibbles in -> nibbles with +3 where >=5
//   - Instantiated once, feeds the shift register.
//  Top: FSM, iteration counter (ceil log2 BIN_W), write index counter (3b), output registers.
// TESTING
//  1. reset pulse mid-idle:
//     -> pos=F, data_out=F, busy=0, done=0, overflow=0 immediately (no clock edge needed).
//  2. value=12_345_678, start 1 cycle at edge k:
//     -> busy from k+1; writes (0,8),(1,7),(2,6),(3,5),(4,4),(5,3),(6,2),(7,1) at k+28..k+35;
//     -> done=1 only at k+36; overflow=0.
//  3. value=0, then value=99_999_999:
//     -> eight writes of 0, then eight writes of 9; overflow=0 both times.
//  4. value=100_000_000 (27'h5F5E100):
//     -> overflow=1, eight writes of 9; next start with 5 -> overflow=0, digits 5,0,0,0,0,0,0,0.
//  5. start held high / re-pulsed during CONV and WRITE, with value changed to 42:
//     -> original sequence unaffected; exactly one done per accepted start.
//  6. reset asserted during WRITE at pos=3:
//     -> outputs idle at once, no write at pos 4;
//     -> after release, start value=87_654_321 completes normally with correct digits.
//  Bench includes a behavioural controller model that checks final stored digits and
//  flags any write with pos<8 while busy=0.

Source files
------------

// File: rtl/display_bin_writer_pkg.sv
// Shared types and constants for the binary-to-BCD display writer.
package display_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    CONV  = 2'd1,
    WRITE = 2'd2,
    DONE  = 2'd3
  } state_t;

  // Position/data code the display controller treats as "no write".
  localparam logic [3:0] POS_IDLE  = 4'hF;
  localparam logic [3:0] DATA_IDLE = 4'hF;

  // Largest value representable in the given number of decimal digits.
  function automatic longint unsigned max_value(input int digits);
    longint unsigned m;
    m = 1;
    for (int i = 0; i < digits; i++) m = m * 10;
    return m - 1;
  endfunction

endpackage

// File: rtl/display_bin_writer_if.sv
// Request/write-port bundle between a requester, the writer and the display controller.
interface display_bin_writer_if #(
  parameter int BIN_W = 27
);
  logic             start;
  logic [BIN_W-1:0] value;
  logic [3:0]       pos;
  logic [3:0]       data_out;
  logic             busy;
  logic             done;
  logic             overflow;

  modport master (
    input  start, value,
    output pos, data_out, busy, done, overflow
  );

  modport slave (
    output start, value,
    input  pos, data_out, busy, done, overflow
  );
endinterface

// File: rtl/display_bin_writer_bcd_add3_step.sv
// Double-dabble correction: every BCD nibble >= 5 gets +3 before the next shift.
module bcd_add3_step #(
  parameter int DIGITS = 8
) (
  input  logic [4*DIGITS-1:0] bcd,
  output logic [4*DIGITS-1:0] adj
);

  always_comb begin
    adj = bcd;
    for (int i = 0; i < DIGITS; i++) begin
      if (bcd[4*i +: 4] >= 4'd5) adj[4*i +: 4] = bcd[4*i +: 4] + 4'd3;
    end
  end

endmodule

// File: rtl/display_bin_writer.sv
// Converts a binary value to BCD (one shift per cycle) and streams the digits,
// least significant first, to the display controller's (pos, data_out) port.
module display_bin_writer
  import display_pkg::*;
#(
  parameter int DIGITS = 8,
  parameter int BIN_W  = 27
) (
  input logic                  clock,
  input logic                  reset,
  display_bin_writer_if.master bus
);

  localparam int BCD_W = 4 * DIGITS;
  localparam int SH_W  = BCD_W + BIN_W;
  localparam int CNT_W = (BIN_W > 1) ? $clog2(BIN_W) : 1;

  localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(BIN_W - 1);
  localparam logic [2:0]       LAST_IDX  = 3'(DIGITS - 1);
  localparam logic [BIN_W-1:0] SAT_VALUE = BIN_W'(max_value(DIGITS));

  state_t           state, state_n;
  logic [SH_W-1:0]  sh_q, sh_n;     // {bcd, bin} double-dabble register
  logic [CNT_W-1:0] iter_q, iter_n;
  logic [2:0]       idx_q, idx_n;
  logic [3:0]       pos_q, pos_n;
  logic [3:0]       data_q, data_n;
  logic             ovf_q, ovf_n;
  logic [BCD_W-1:0] adj;
  logic [SH_W-1:0]  shifted;

  bcd_add3_step #(.DIGITS(DIGITS)) u_add3 (
    .bcd (sh_q[SH_W-1 -: BCD_W]),
    .adj (adj)
  );

  assign shifted = {adj, sh_q[BIN_W-1:0]} << 1;

  // NOTE: every next-value is defaulted to its current value first so this block never infers a latch.
  always_comb begin
    state_n = state;
    sh_n    = sh_q;
    iter_n  = iter_q;
    idx_n   = idx_q;
    pos_n   = pos_q;
    data_n  = data_q;
    ovf_n   = ovf_q;

    unique case (state)
      IDLE: begin
        if (bus.start) begin
          ovf_n   = (64'(bus.value) > max_value(DIGITS));
          sh_n    = {{BCD_W{1'b0}}, (ovf_n ? SAT_VALUE : bus.value)};
          iter_n  = '0;
          idx_n   = '0;
          state_n = CONV;
        end
      end

      CONV: begin
        sh_n   = shifted;
        iter_n = iter_q + 1'b1;
        // Final shift: the first digit is taken straight from the shifter so
        // the first write lands in the very next cycle.
        if (iter_q == LAST_ITER) begin
          iter_n  = '0;
          pos_n   = 4'd0;
          data_n  = shifted[BIN_W +: 4];
          state_n = WRITE;
        end
      end

      WRITE: begin
        if (idx_q == LAST_IDX) begin
          pos_n   = POS_IDLE;
          data_n  = DATA_IDLE;
          state_n = DONE;
        end else begin
          idx_n  = idx_q + 1'b1;
          pos_n  = 4'(idx_n);
          data_n = sh_q[BIN_W + 4*int'(idx_n) +: 4];
        end
      end

      DONE: begin
        idx_n   = '0;
        state_n = IDLE;
      end

      default: state_n = IDLE;
    endcase
  end

  // NOTE: sequential state is updated with non-blocking assignments so all registers see pre-edge values.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state  <= IDLE;
      sh_q   <= '0;
      iter_q <= '0;
      idx_q  <= '0;
      pos_q  <= POS_IDLE;
      data_q <= DATA_IDLE;
      ovf_q  <= 1'b0;
    end else begin
      state  <= state_n;
      sh_q   <= sh_n;
      iter_q <= iter_n;
      idx_q  <= idx_n;
      pos_q  <= pos_n;
      data_q <= data_n;
      ovf_q  <= ovf_n;
    end
  end

  assign bus.pos      = pos_q;
  assign bus.data_out = data_q;
  assign bus.busy     = (state == CONV) || (state == WRITE);
  assign bus.done     = (state == DONE);
  assign bus.overflow = ovf_q;

endmodule

// File: tb/tb_display_bin_writer.sv
// Directed bench for display_bin_writer with a behavioural display-controller model.
module tb_display_bin_writer;

  logic clock;
  logic reset;

  int n_cmp = 0;
  int n_err = 0;
  int viol  = 0;

  logic [31:0] ctrl_bcd = '0;   // digits held by the modelled controller

  display_bin_writer_if #(.BIN_W(27)) bus ();

  display_bin_writer #(.DIGITS(8), .BIN_W(27)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Controller model plus protocol monitor, sampled mid-cycle.
  always @(negedge clock) begin
    if (bus.pos < 4'd8) begin
      if (!bus.busy) viol++;
      ctrl_bcd[4*int'(bus.pos) +: 4] = bus.data_out;
    end else if (bus.pos != 4'hF) begin
      viol++;
    end
    if (bus.busy && bus.done) viol++;
  end

  // One full request. j counts negedges after the accepting edge k, so
  // sample j corresponds to cycle k+j.
  task automatic run_seq(input logic [26:0] v, input logic [31:0] exp_bcd,
                         input logic exp_ovf, input bit disturb, input string tag);
    int done_cnt;
    logic [31:0] exp_digits;
    exp_digits = exp_bcd;
    done_cnt   = 0;
    @(negedge clock);
    bus.value = v;
    bus.start = 1'b1;
    for (int j = 1; j <= 40; j++) begin
      @(negedge clock);
      if (disturb && j <= 36) begin
        bus.start = (j % 3 != 0);
        bus.value = 27'd42;
      end else begin
        bus.start = 1'b0;
      end
      if (j == 1) begin
        check($sformatf("%s_busy_k1", tag), 32'(bus.busy), 32'd1);
        check($sformatf("%s_ovf", tag), 32'(bus.overflow), 32'(exp_ovf));
      end
      if (j == 27) check($sformatf("%s_no_early_write", tag), 32'(bus.pos), 32'hF);
      if (j >= 28 && j <= 35) begin
        check($sformatf("%s_pos%0d", tag, j - 28), 32'(bus.pos), 32'(j - 28));
        check($sformatf("%s_data%0d", tag, j - 28), 32'(bus.data_out),
              32'(exp_digits[4*(j-28) +: 4]));
      end
      if (j == 36) begin
        check($sformatf("%s_done_k36", tag), 32'(bus.done), 32'd1);
        check($sformatf("%s_busy_k36", tag), 32'(bus.busy), 32'd0);
        check($sformatf("%s_pos_k36", tag), 32'(bus.pos), 32'hF);
      end
      if (bus.done) done_cnt++;
    end
    check($sformatf("%s_done_count", tag), 32'(done_cnt), 32'd1);
    check($sformatf("%s_ctrl_digits", tag), ctrl_bcd, exp_bcd);
    check($sformatf("%s_ovf_held", tag), 32'(bus.overflow), 32'(exp_ovf));
  endtask

  initial begin
    #100us;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

  initial begin
    reset     = 1'b1;
    bus.start = 1'b0;
    bus.value = '0;
    #1;
    check("rst_pos", 32'(bus.pos), 32'hF);
    check("rst_data", 32'(bus.data_out), 32'hF);
    check("rst_busy", 32'(bus.busy), 32'd0);
    check("rst_done", 32'(bus.done), 32'd0);
    check("rst_ovf", 32'(bus.overflow), 32'd0);
    @(negedge clock);
    reset = 1'b0;
    repeat (2) @(negedge clock);

    run_seq(27'd12_345_678,  32'h12345678, 1'b0, 1'b0, "bin12345678");
    run_seq(27'd0,           32'h00000000, 1'b0, 1'b0, "bin0");
    run_seq(27'd99_999_999,  32'h99999999, 1'b0, 1'b0, "bin99999999");
    run_seq(27'd100_000_000, 32'h99999999, 1'b1, 1'b0, "bin_ovf");

    // Asynchronous reset mid-idle clears the latched overflow without a clock edge.
    @(negedge clock);
    #2 reset = 1'b1;
    #1;
    check("rstidle_ovf", 32'(bus.overflow), 32'd0);
    check("rstidle_pos", 32'(bus.pos), 32'hF);
    check("rstidle_busy", 32'(bus.busy), 32'd0);
    #1 reset = 1'b0;

    run_seq(27'd5,          32'h00000005, 1'b0, 1'b0, "bin5");
    run_seq(27'd31_415_926, 32'h31415926, 1'b0, 1'b1, "disturb");

    // Abort during the write of pos 3: digits 7,5,3,1 reach the controller, nothing more.
    @(negedge clock);
    bus.value = 27'd24_681_357;
    bus.start = 1'b1;
    @(negedge clock);
    bus.start = 1'b0;
    repeat (30) @(negedge clock);
    check("abort_pos3", 32'(bus.pos), 32'd3);
    check("abort_data3", 32'(bus.data_out), 32'd1);
    #2 reset = 1'b1;
    #1;
    check("abort_pos", 32'(bus.pos), 32'hF);
    check("abort_data", 32'(bus.data_out), 32'hF);
    check("abort_busy", 32'(bus.busy), 32'd0);
    check("abort_done", 32'(bus.done), 32'd0);
    repeat (2) @(negedge clock);
    reset = 1'b0;
    repeat (10) @(negedge clock);
    check("abort_idle_pos", 32'(bus.pos), 32'hF);
    check("abort_ctrl_digits", ctrl_bcd, 32'h31411357);

    run_seq(27'd87_654_321, 32'h87654321, 1'b0, 1'b0, "after_abort");

    check("monitor_violations", 32'(viol), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
